// File: rtl/csa_seq_adder.sv
// Sequential wide adder: walks WIDTH-bit operands through one 4-bit
// carry-select slice, LSB slice first, chaining the carry through a register.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. in_ready is high only in IDLE and
// out_valid only in DONE, so the two are never high together. The producer
// may drop in_valid at any time; in_valid outside IDLE is ignored. Once
// out_valid rises, sum/cout stay stable until out_ready is seen.

// 4-bit carry-select slice: low pair ripples, high pair is precomputed for
// both carry values and selected by the low-pair carry.
module csa (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [2:0] lo;
    logic [2:0] hi0;
    logic [2:0] hi1;

    // Both high-pair candidates are formed in parallel with the low pair.
    always_comb begin
        lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
        hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
        hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
        if (lo[2]) begin
            s    = {hi1[1:0], lo[1:0]};
            cout = hi1[2];
        end else begin
            s    = {hi0[1:0], lo[1:0]};
            cout = hi0[2];
        end
    end
endmodule

// WIDTH must be a multiple of 4 and at least 4.
module csa_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // state is kept as a plain named register so checkers can bind to it.
    state_t          state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic            carry_r;
    logic [IW-1:0]   idx;

    logic [3:0]      slice_a;
    logic [3:0]      slice_b;
    logic [3:0]      slice_s;
    logic            slice_cout;
    logic            last_slice;

    // Select the operand nibble for the slice currently being processed.
    always_comb begin
        slice_a    = a_r[4*idx +: 4];
        slice_b    = b_r[4*idx +: 4];
        last_slice = (idx == IW'(NSLICE - 1));
    end

    csa u_csa (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_r),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // Control FSM with registered handshake outputs and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            idx       <= '0;
            carry_r   <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        carry_r  <= cin;
                        idx      <= '0;
                        sum      <= '0;
                        cout     <= 1'b0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    sum[4*idx +: 4] <= slice_s;
                    carry_r         <= slice_cout;
                    if (last_slice) begin
                        cout      <= slice_cout;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    // Result is held until the consumer takes it.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_csa_seq_adder.sv
// Testbench for csa_seq_adder: directed checks on a 16-bit instance, then
// concurrent randomized traffic on 16-, 4- and 32-bit instances against an
// arithmetic golden model (a+b+cin) held in per-instance expected queues.
module tb_csa_seq_adder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit rand_go = 1'b0;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- directed instance (WIDTH=16) ----------------
    logic        d_in_valid = 1'b0;
    logic        d_in_ready;
    logic [15:0] d_a = '0;
    logic [15:0] d_b = '0;
    logic        d_cin = 1'b0;
    logic        d_out_valid;
    logic        d_out_ready = 1'b0;
    logic [15:0] d_sum;
    logic        d_cout;
    logic        d_busy;

    csa_seq_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .a         (d_a),
        .b         (d_b),
        .cin       (d_cin),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .sum       (d_sum),
        .cout      (d_cout),
        .busy      (d_busy)
    );

    // ---------------- driver tasks ----------------
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!d_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check({tag, "_idle_timeout"}, 64'(d_in_ready), 64'd1);
    endtask

    // Issue one operation, then wait for its result with out_ready held high.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tbv,
                          input logic tc, input logic [15:0] es, input logic ec);
        int lat;
        wait_idle(tag);
        d_a = ta; d_b = tbv; d_cin = tc; d_in_valid = 1'b1; d_out_ready = 1'b1;
        @(posedge clk);
        #1;
        d_in_valid = 1'b0;
        lat = 0;
        while (!d_out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd4);
        check({tag, "_sum"}, 64'(d_sum), 64'(es));
        check({tag, "_cout"}, 64'(d_cout), 64'(ec));
    endtask

    // ---------------- randomized instances ----------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_rand
        localparam int W     = (gi == 0) ? 16 : ((gi == 1) ? 4 : 32);
        localparam int N_OPS = 700;

        logic         in_valid = 1'b0;
        logic         in_ready;
        logic [W-1:0] a = '0;
        logic [W-1:0] b = '0;
        logic         cin = 1'b0;
        logic         out_valid;
        logic         out_ready = 1'b0;
        logic [W-1:0] sum;
        logic         cout;
        logic         busy;
        bit           done = 1'b0;
        logic [W:0]   exp_q[$];

        csa_seq_adder #(.WIDTH(W)) dut_r (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .cout      (cout),
            .busy      (busy)
        );

        // Drive at the falling edge; registered handshakes seen here are
        // exactly what the DUT sees at the following rising edge.
        initial begin : rand_run
            int n_acc;
            int n_res;
            int cyc;
            logic [W:0] e;
            wait (rand_go);
            n_acc = 0; n_res = 0; cyc = 0;
            while (n_res < N_OPS && cyc < 30000) begin
                @(negedge clk);
                cyc++;
                in_valid  = (n_acc < N_OPS) && ($urandom_range(0, 9) < 7);
                a         = W'($urandom());
                b         = W'($urandom());
                cin       = 1'($urandom_range(0, 1));
                out_ready = ($urandom_range(0, 9) < 7);
                check($sformatf("w%0d_excl", W), 64'(in_ready & out_valid), 64'd0);
                if (in_valid && in_ready) begin
                    exp_q.push_back({1'b0, a} + {1'b0, b} + (W+1)'(cin));
                    n_acc++;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("w%0d_dup", W), 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("w%0d_res", W), 64'({cout, sum}), 64'(e));
                    end
                    n_res++;
                end
            end
            check($sformatf("w%0d_count", W), 64'(n_res), 64'(N_OPS));
            check($sformatf("w%0d_left", W), 64'(exp_q.size()), 64'd0);
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b0;
            done = 1'b1;
        end
    end

    // ---------------- directed sequence and report ----------------
    initial begin
        int n;
        int cyc;

        // 1. reset, idle 5 cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(d_in_ready), 64'd1);
        check("rst_out_valid", 64'(d_out_valid), 64'd0);
        check("rst_busy", 64'(d_busy), 64'd0);
        check("rst_sum", 64'(d_sum), 64'd0);
        check("rst_cout", 64'(d_cout), 64'd0);

        // 2./3. basic and carry-boundary vectors
        run_op("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        run_op("ripple",  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        run_op("msb",     16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
        run_op("nib",     16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0);

        // 4. backpressure: result held, new request ignored
        wait_idle("bp");
        d_a = 16'h00FF; d_b = 16'h0001; d_cin = 1'b0; d_in_valid = 1'b1; d_out_ready = 1'b0;
        @(posedge clk);
        #1 d_in_valid = 1'b0;
        n = 0;
        while (!d_out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        check("bp_lat", 64'(n), 64'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            d_in_valid = 1'b1; d_a = 16'h1111; d_b = 16'h1111;
            check("bp_hold_sum", 64'(d_sum), 64'h0100);
            check("bp_hold_valid", 64'(d_out_valid), 64'd1);
            check("bp_in_ready", 64'(d_in_ready), 64'd0);
        end
        check("bp_cout", 64'(d_cout), 64'd0);
        @(negedge clk);
        d_in_valid = 1'b0; d_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 64'(d_out_valid), 64'd0);
        check("bp_release_ready", 64'(d_in_ready), 64'd1);
        @(posedge clk);
        #1;
        check("bp_no_queued_op", 64'(d_busy), 64'd0);

        // 5. reset mid-RUN aborts, then a clean operation
        wait_idle("abort");
        d_a = 16'h1234; d_b = 16'h1111; d_cin = 1'b0; d_in_valid = 1'b1; d_out_ready = 1'b1;
        @(posedge clk);
        #1 d_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_in_ready", 64'(d_in_ready), 64'd1);
        check("abort_out_valid", 64'(d_out_valid), 64'd0);
        check("abort_sum", 64'(d_sum), 64'd0);
        check("abort_busy", 64'(d_busy), 64'd0);
        rst = 1'b0;
        run_op("post_abort", 16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0);
        @(negedge clk);
        d_out_ready = 1'b0;

        // 6. randomized traffic on all three widths
        rand_go = 1'b1;
        cyc = 0;
        while (!(g_rand[0].done && g_rand[1].done && g_rand[2].done) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
        end
        check("rand_all_done",
              64'(g_rand[0].done && g_rand[1].done && g_rand[2].done), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
